// File: rtl/divider.sv
// Multi-cycle IEEE-754 binary32 divider (z = a / b) with round-to-nearest-even
// and denormal support; strobe-in / one-cycle done-pulse handshake.
module divider (
  input  logic        clk,
  input  logic        reset_ni,
  input  logic [31:0] a_value_i,
  input  logic [31:0] b_value_i,
  input  logic        exec_strobe_i,
  output logic [31:0] z_value_o,
  output logic        done_strobe_o
);

  typedef enum logic [3:0] {
    IDLE, UNPACK, SPECIAL_CASES, NORMALIZE_A, NORMALIZE_B,
    DIVIDE_0, DIVIDE_1, DIVIDE_2, NORMALIZE_0, NORMALIZE_1,
    ROUND, PACK, DONE
  } state_t;

  state_t state, state_next;

  logic [31:0]       a, b, z;
  logic [23:0]       a_m, b_m, z_m, divisor;
  logic signed [9:0] a_e, b_e, z_e;
  logic              a_s, b_s, z_s;
  logic              guard, round_bit, sticky;
  logic [50:0]       dividend, remainder, rem_shift;
  // Only the low 27 quotient bits ever reach the rounding fields.
  logic [26:0]       quotient;
  logic [5:0]        count;
  logic              done_d;

  logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, special;

  assign a_nan   = (a_e == 10'sd128) && (a_m != '0);
  assign b_nan   = (b_e == 10'sd128) && (b_m != '0);
  assign a_inf   = (a_e == 10'sd128) && (a_m == '0);
  assign b_inf   = (b_e == 10'sd128) && (b_m == '0);
  assign a_zero  = (a_e == -10'sd127) && (a_m == '0);
  assign b_zero  = (b_e == -10'sd127) && (b_m == '0);
  assign special = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;

  assign rem_shift = {remainder[49:0], dividend[50]};

  always_ff @(posedge clk) begin
    if (!reset_ni) begin
      state         <= IDLE;
      done_strobe_o <= 1'b0;
      z_value_o     <= '0;
    end else begin
      state         <= state_next;
      done_strobe_o <= done_d;
      if (done_d) z_value_o <= z;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:          if (exec_strobe_i) state_next = UNPACK;
      UNPACK:        state_next = SPECIAL_CASES;
      SPECIAL_CASES: state_next = special ? DONE : NORMALIZE_A;
      NORMALIZE_A:   if (a_m[23]) state_next = NORMALIZE_B;
      NORMALIZE_B:   if (b_m[23]) state_next = DIVIDE_0;
      DIVIDE_0:      state_next = DIVIDE_1;
      DIVIDE_1:      if (count == 6'd49) state_next = DIVIDE_2;
      DIVIDE_2:      state_next = NORMALIZE_0;
      NORMALIZE_0:   if (z_m[23] || (z_e <= -10'sd126)) state_next = NORMALIZE_1;
      NORMALIZE_1:   if (z_e >= -10'sd126) state_next = ROUND;
      ROUND:         state_next = PACK;
      PACK:          state_next = DONE;
      DONE:          state_next = IDLE;
      default:       state_next = IDLE;
    endcase
  end

  always_comb begin
    done_d = (state == DONE);
  end

  always_ff @(posedge clk) begin
    case (state)
      IDLE: begin
        if (exec_strobe_i) begin
          a <= a_value_i;
          b <= b_value_i;
        end
      end
      UNPACK: begin
        a_m <= {1'b0, a[22:0]};
        b_m <= {1'b0, b[22:0]};
        a_e <= $signed({2'b00, a[30:23]}) - 10'sd127;
        b_e <= $signed({2'b00, b[30:23]}) - 10'sd127;
        a_s <= a[31];
        b_s <= b[31];
      end
      SPECIAL_CASES: begin
        if (a_nan || b_nan)     z <= 32'hFFC0_0000;
        else if (a_inf && b_inf) z <= 32'hFFC0_0000;
        else if (a_inf)         z <= {a_s ^ b_s, 8'hFF, 23'h0};
        else if (b_inf)         z <= {a_s ^ b_s, 31'h0};
        else if (b_zero)        z <= a_zero ? 32'hFFC0_0000 : {a_s ^ b_s, 8'hFF, 23'h0};
        else if (a_zero)        z <= {a_s ^ b_s, 31'h0};
        else begin
          if (a_e == -10'sd127) a_e <= -10'sd126;
          else                  a_m[23] <= 1'b1;
          if (b_e == -10'sd127) b_e <= -10'sd126;
          else                  b_m[23] <= 1'b1;
        end
      end
      NORMALIZE_A: begin
        if (!a_m[23]) begin
          a_m <= a_m << 1;
          a_e <= a_e - 10'sd1;
        end
      end
      NORMALIZE_B: begin
        if (!b_m[23]) begin
          b_m <= b_m << 1;
          b_e <= b_e - 10'sd1;
        end
      end
      DIVIDE_0: begin
        z_s       <= a_s ^ b_s;
        z_e       <= a_e - b_e;
        dividend  <= {a_m, 27'h0};
        divisor   <= b_m;
        quotient  <= '0;
        remainder <= '0;
        count     <= '0;
      end
      DIVIDE_1: begin
        dividend <= dividend << 1;
        count    <= count + 6'd1;
        if (rem_shift >= {27'h0, divisor}) begin
          quotient  <= {quotient[25:0], 1'b1};
          remainder <= rem_shift - {27'h0, divisor};
        end else begin
          quotient  <= {quotient[25:0], 1'b0};
          remainder <= rem_shift;
        end
      end
      DIVIDE_2: begin
        z_m       <= quotient[26:3];
        guard     <= quotient[2];
        round_bit <= quotient[1];
        sticky    <= quotient[0] | (remainder != '0);
      end
      NORMALIZE_0: begin
        if (!z_m[23] && (z_e > -10'sd126)) begin
          z_e       <= z_e - 10'sd1;
          z_m       <= {z_m[22:0], guard};
          guard     <= round_bit;
          round_bit <= 1'b0;
        end
      end
      NORMALIZE_1: begin
        if (z_e < -10'sd126) begin
          z_e       <= z_e + 10'sd1;
          z_m       <= z_m >> 1;
          guard     <= z_m[0];
          round_bit <= guard;
          sticky    <= sticky | round_bit;
        end
      end
      ROUND: begin
        if (guard && (round_bit || sticky || z_m[0])) begin
          z_m <= z_m + 24'd1;
          if (z_m == 24'hFF_FFFF) z_e <= z_e + 10'sd1;
        end
      end
      PACK: begin
        if (z_e > 10'sd127)
          z <= {z_s, 8'hFF, 23'h0};
        else if ((z_e == -10'sd126) && !z_m[23])
          z <= {z_s, 8'h00, z_m[22:0]};
        else
          z <= {z_s, z_e[7:0] + 8'd127, z_m[22:0]};
      end
      default: ;
    endcase
  end

endmodule
